// File: rtl/regfile_mt_if.sv
// ============================================================================
// Module   : regfile_mt_if
// Brief    : Port bundle for regfile_mt: register access, flags and the
//            multi-register transfer handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface regfile_mt_if #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int AW     = $clog2(NREG)
);
    logic [DATA_W-1:0] pc_i;
    logic [1:0]        ir_cz_i;
    logic [2:0]        f_sel_i;
    logic              c_in_i;
    logic              z_in_i;
    logic              we_i;
    logic [AW-1:0]     ra1_i;
    logic [AW-1:0]     ra2_i;
    logic [AW-1:0]     wa_i;
    logic [DATA_W-1:0] wd_i;
    logic [DATA_W-1:0] rd1_o;
    logic [DATA_W-1:0] rd2_o;
    logic              c_flag_o;
    logic              z_flag_o;
    logic              mt_start_i;
    logic              mt_load_i;
    logic [NREG-1:0]   mt_mask_i;
    logic              mt_valid_o;
    logic              mt_ready_i;
    logic [AW-1:0]     mt_idx_o;
    logic [DATA_W-1:0] mt_rdata_o;
    logic [DATA_W-1:0] mt_wdata_i;
    logic              mt_busy_o;
    logic              mt_done_o;

    modport slave (
        input  pc_i, ir_cz_i, f_sel_i, c_in_i, z_in_i, we_i,
        input  ra1_i, ra2_i, wa_i, wd_i,
        output rd1_o, rd2_o, c_flag_o, z_flag_o,
        input  mt_start_i, mt_load_i, mt_mask_i, mt_ready_i, mt_wdata_i,
        output mt_valid_o, mt_idx_o, mt_rdata_o, mt_busy_o, mt_done_o
    );

    modport master (
        output pc_i, ir_cz_i, f_sel_i, c_in_i, z_in_i, we_i,
        output ra1_i, ra2_i, wa_i, wd_i,
        input  rd1_o, rd2_o, c_flag_o, z_flag_o,
        output mt_start_i, mt_load_i, mt_mask_i, mt_ready_i, mt_wdata_i,
        input  mt_valid_o, mt_idx_o, mt_rdata_o, mt_busy_o, mt_done_o
    );
endinterface

`default_nettype wire

// File: rtl/regfile_mt.sv
// ============================================================================
// Module   : regfile_mt
// Brief    : Register file with PC-mirrored R0, C/Z flags, predicated write,
//            write-to-read bypass and an LM/SM multi-register sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_mt #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter bit BYPASS = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    regfile_mt_if.slave    bus
);
    localparam int              AW      = $clog2(NREG);
    localparam logic [1:0]      C_CZ_C  = 2'b10;
    localparam logic [1:0]      C_CZ_Z  = 2'b01;
    localparam logic [2:0]      C_F_ADD = 3'b000;
    localparam logic [2:0]      C_F_LIM = 3'b011;
    localparam logic [NREG-1:0] C_ONE   = NREG'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREG-1:0]   rem_q, rem_d;
    logic              load_q, load_d;
    logic [DATA_W-1:0] regs_q [NREG];
    logic              c_q;
    logic              z_q;

    logic              w_busy;
    logic              w_cmd;
    logic              w_pred;
    logic              w_norm_wen;
    logic              w_lm_wen;
    logic              w_wr_en;
    logic [AW-1:0]     w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic [AW-1:0]     w_idx;
    logic [NREG-1:0]   w_start_mask;

    // R0 always holds the PC, so the sequencer never touches it
    assign w_start_mask = bus.mt_mask_i & ~C_ONE;

    assign w_busy     = (state_q != S_IDLE);
    assign w_cmd      = bus.we_i & ~w_busy;
    assign w_pred     = ~((bus.ir_cz_i == C_CZ_C) & ~c_q) & ~((bus.ir_cz_i == C_CZ_Z) & ~z_q);
    assign w_norm_wen = w_cmd & w_pred & (bus.wa_i != '0);
    assign w_lm_wen   = (state_q == S_XFER) & load_q & bus.mt_ready_i;

    // Normal and LM writes are mutually exclusive: the normal port is gated by busy
    assign w_wr_en   = w_norm_wen | w_lm_wen;
    assign w_wr_addr = w_lm_wen ? w_idx : bus.wa_i;
    assign w_wr_data = w_lm_wen ? bus.mt_wdata_i : bus.wd_i;

    // Lowest set bit of the remaining mask; descending scan lets the lowest win
    always_comb begin
        w_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (rem_q[i]) begin
                w_idx = AW'(i);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        load_d         = load_q;
        bus.mt_valid_o = 1'b0;
        bus.mt_done_o  = 1'b0;
        bus.mt_busy_o  = w_busy;
        case (state_q)
            S_IDLE: begin
                if (bus.mt_start_i) begin
                    rem_d   = w_start_mask;
                    load_d  = bus.mt_load_i;
                    state_d = (w_start_mask != '0) ? S_XFER : S_DONE;
                end
            end
            S_XFER: begin
                bus.mt_valid_o = 1'b1;
                if (bus.mt_ready_i) begin
                    rem_d = rem_q & (rem_q - C_ONE);
                    if (rem_d == '0) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                bus.mt_done_o = 1'b1;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.mt_idx_o   = w_idx;
    assign bus.mt_rdata_o = regs_q[w_idx];
    assign bus.c_flag_o   = c_q;
    assign bus.z_flag_o   = z_q;

    // Address 0 reads as zero even though R0 stores the PC
    always_comb begin
        bus.rd1_o = regs_q[bus.ra1_i];
        if (bus.ra1_i == '0) begin
            bus.rd1_o = '0;
        end else if (BYPASS && w_wr_en && (w_wr_addr == bus.ra1_i)) begin
            bus.rd1_o = w_wr_data;
        end
    end

    always_comb begin
        bus.rd2_o = regs_q[bus.ra2_i];
        if (bus.ra2_i == '0) begin
            bus.rd2_o = '0;
        end else if (BYPASS && w_wr_en && (w_wr_addr == bus.ra2_i)) begin
            bus.rd2_o = w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            load_q  <= 1'b0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            load_q  <= load_d;
            if (w_cmd && (bus.f_sel_i == C_F_ADD)) begin
                c_q <= bus.c_in_i;
            end
            if (w_cmd && (bus.f_sel_i < C_F_LIM)) begin
                z_q <= bus.z_in_i;
            end
            if (w_wr_en) begin
                regs_q[w_wr_addr] <= w_wr_data;
            end
            regs_q[0] <= bus.pc_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mt.sv
// ============================================================================
// Module   : tb_regfile_mt
// Brief    : Self-checking bench for regfile_mt against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mt;
    localparam int DW = 16;
    localparam int NR = 8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [DW-1:0] m_r [NR];
    logic          m_c;
    logic          m_z;
    bit            m_busy;

    regfile_mt_if #(.DATA_W(DW), .NREG(NR)) bus ();

    regfile_mt #(.DATA_W(DW), .NREG(NR), .BYPASS(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: the model applies the architectural rules to the inputs in force
    task automatic cycle();
        bit pred;
        if (!m_busy && bus.we_i) begin
            pred = !((bus.ir_cz_i == 2'b10 && !m_c) || (bus.ir_cz_i == 2'b01 && !m_z));
            if (pred && bus.wa_i != 0) m_r[bus.wa_i] = bus.wd_i;
            if (bus.f_sel_i == 3'd0) m_c = bus.c_in_i;
            if (bus.f_sel_i < 3'd3)  m_z = bus.z_in_i;
        end
        m_r[0] = bus.pc_i;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) m_r[i] = '0;
        m_c = 1'b0;
        m_z = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.pc_i = 16'h0040;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        checks++; if (dut.regs_q[0] !== 16'h0000) begin errors++; $display("FAIL reset_r0 got %h want 0000", dut.regs_q[0]); end
        checks++; if (bus.c_flag_o !== 1'b0 || bus.z_flag_o !== 1'b0) begin errors++; $display("FAIL reset_flags got c=%b z=%b want 0 0", bus.c_flag_o, bus.z_flag_o); end
        checks++; if (bus.mt_busy_o !== 1'b0 || bus.mt_valid_o !== 1'b0 || bus.mt_done_o !== 1'b0) begin
            errors++; $display("FAIL reset_mt got busy=%b valid=%b done=%b want 0 0 0", bus.mt_busy_o, bus.mt_valid_o, bus.mt_done_o);
        end
        cycle();
        checks++; if (dut.regs_q[0] !== m_r[0]) begin errors++; $display("FAIL r0_pc got %h want %h", dut.regs_q[0], m_r[0]); end
        bus.ra1_i = '0; #1;
        checks++; if (bus.rd1_o !== 16'h0000) begin errors++; $display("FAIL rd_r0 got %h want 0000", bus.rd1_o); end
        for (int i = 1; i < NR; i++) begin
            bus.ra1_i = 3'(i); #1;
            checks++; if (bus.rd1_o !== 16'h0000) begin errors++; $display("FAIL reset_r%0d got %h want 0000", i, bus.rd1_o); end
        end
    endtask

    task automatic test_predicate();
        bus.we_i = 1'b1; bus.ir_cz_i = 2'b00; bus.f_sel_i = 3'b000;
        bus.c_in_i = 1'b0; bus.z_in_i = 1'b0; bus.wa_i = 3'd0; bus.wd_i = 16'h9999;
        cycle();
        bus.ir_cz_i = 2'b10; bus.wa_i = 3'd3; bus.wd_i = 16'h1234; bus.c_in_i = 1'b1;
        cycle();
        bus.we_i = 1'b0; bus.ra1_i = 3'd3; #1;
        checks++; if (bus.rd1_o !== m_r[3]) begin errors++; $display("FAIL pred_c_blocked got %h want %h", bus.rd1_o, m_r[3]); end
        checks++; if (bus.c_flag_o !== 1'b1) begin errors++; $display("FAIL pred_c_flag got %b want 1", bus.c_flag_o); end
        bus.we_i = 1'b1;
        cycle();
        bus.we_i = 1'b0; #1;
        checks++; if (bus.rd1_o !== 16'h1234) begin errors++; $display("FAIL pred_c_pass got %h want 1234", bus.rd1_o); end
        // Z-predicated write with Z currently clear, on a Z-only op
        bus.we_i = 1'b1; bus.ir_cz_i = 2'b01; bus.f_sel_i = 3'b010; bus.z_in_i = 1'b1;
        bus.wa_i = 3'd4; bus.wd_i = 16'h4444;
        cycle();
        bus.we_i = 1'b0; bus.ra1_i = 3'd4; #1;
        checks++; if (bus.rd1_o !== m_r[4] || bus.z_flag_o !== m_z) begin
            errors++; $display("FAIL pred_z got r4=%h z=%b want %h %b", bus.rd1_o, bus.z_flag_o, m_r[4], m_z);
        end
    endtask

    task automatic test_bypass();
        bus.we_i = 1'b1; bus.ir_cz_i = 2'b00; bus.f_sel_i = 3'b111;
        bus.wa_i = 3'd5; bus.wd_i = 16'hBEEF; bus.ra2_i = 3'd5; bus.ra1_i = 3'd0; #1;
        checks++; if (bus.rd2_o !== 16'hBEEF) begin errors++; $display("FAIL bypass got %h want beef", bus.rd2_o); end
        cycle();
        bus.wa_i = 3'd0; bus.wd_i = 16'hFFFF; bus.pc_i = 16'h1111; #1;
        checks++; if (bus.rd1_o !== 16'h0000) begin errors++; $display("FAIL bypass_r0 got %h want 0000", bus.rd1_o); end
        cycle();
        checks++; if (dut.regs_q[0] !== 16'h1111) begin errors++; $display("FAIL r0_write_dropped got %h want 1111", dut.regs_q[0]); end
        bus.we_i = 1'b0;
    endtask

    task automatic test_random();
        bit pred;
        logic [DW-1:0] e1, e2;
        for (int n = 0; n < 200; n++) begin
            bus.we_i    = 1'($urandom_range(0, 1));
            bus.ir_cz_i = 2'($urandom_range(0, 3));
            bus.f_sel_i = 3'($urandom_range(0, 7));
            bus.c_in_i  = 1'($urandom_range(0, 1));
            bus.z_in_i  = 1'($urandom_range(0, 1));
            bus.wa_i    = 3'($urandom_range(0, 7));
            bus.ra1_i   = 3'($urandom_range(0, 7));
            bus.ra2_i   = 3'($urandom_range(0, 7));
            bus.wd_i    = 16'($urandom);
            bus.pc_i    = 16'($urandom);
            pred = bus.we_i && !((bus.ir_cz_i == 2'b10 && !m_c) || (bus.ir_cz_i == 2'b01 && !m_z)) && bus.wa_i != 0;
            e1 = (bus.ra1_i == 0) ? 16'h0 : (pred && bus.wa_i == bus.ra1_i) ? bus.wd_i : m_r[bus.ra1_i];
            e2 = (bus.ra2_i == 0) ? 16'h0 : (pred && bus.wa_i == bus.ra2_i) ? bus.wd_i : m_r[bus.ra2_i];
            #1;
            checks++; if (bus.rd1_o !== e1) begin errors++; $display("FAIL rand_rd1 n=%0d got %h want %h", n, bus.rd1_o, e1); end
            checks++; if (bus.rd2_o !== e2) begin errors++; $display("FAIL rand_rd2 n=%0d got %h want %h", n, bus.rd2_o, e2); end
            cycle();
            checks++; if (bus.c_flag_o !== m_c || bus.z_flag_o !== m_z) begin
                errors++; $display("FAIL rand_flags n=%0d got c=%b z=%b want %b %b", n, bus.c_flag_o, bus.z_flag_o, m_c, m_z);
            end
        end
        bus.we_i = 1'b0;
    endtask

    task automatic test_sm();
        int exp_idx [4] = '{1, 2, 5, 7};
        bus.we_i = 1'b1; bus.ir_cz_i = 2'b00; bus.f_sel_i = 3'b111;
        foreach (exp_idx[k]) begin
            bus.wa_i = 3'(exp_idx[k]); bus.wd_i = 16'(exp_idx[k]);
            cycle();
        end
        bus.we_i = 1'b0;
        bus.mt_start_i = 1'b1; bus.mt_load_i = 1'b0; bus.mt_mask_i = 8'b1010_0111;
        cycle();
        bus.mt_start_i = 1'b0;
        m_busy = 1'b1;
        bus.we_i = 1'b1; bus.wa_i = 3'd1; bus.wd_i = 16'hDEAD; bus.f_sel_i = 3'b000;
        bus.c_in_i = ~m_c; bus.z_in_i = ~m_z; bus.mt_ready_i = 1'b1; bus.ra1_i = 3'd1;
        foreach (exp_idx[k]) begin
            #1;
            checks++; if (bus.mt_valid_o !== 1'b1 || bus.mt_idx_o !== 3'(exp_idx[k]) || bus.mt_rdata_o !== m_r[exp_idx[k]]) begin
                errors++; $display("FAIL sm_elem%0d got v=%b idx=%0d d=%h want 1 %0d %h", k, bus.mt_valid_o, bus.mt_idx_o, bus.mt_rdata_o, exp_idx[k], m_r[exp_idx[k]]);
            end
            checks++; if (bus.rd1_o !== m_r[1]) begin errors++; $display("FAIL sm_we_ignored got %h want %h", bus.rd1_o, m_r[1]); end
            cycle();
        end
        checks++; if (bus.mt_done_o !== 1'b1 || bus.mt_valid_o !== 1'b0 || bus.mt_busy_o !== 1'b1) begin
            errors++; $display("FAIL sm_done got d=%b v=%b b=%b want 1 0 1", bus.mt_done_o, bus.mt_valid_o, bus.mt_busy_o);
        end
        cycle();
        m_busy = 1'b0;
        bus.we_i = 1'b0; bus.mt_ready_i = 1'b0;
        checks++; if (bus.mt_busy_o !== 1'b0 || bus.mt_done_o !== 1'b0) begin
            errors++; $display("FAIL sm_idle got b=%b d=%b want 0 0", bus.mt_busy_o, bus.mt_done_o);
        end
        checks++; if (bus.c_flag_o !== m_c || bus.z_flag_o !== m_z) begin
            errors++; $display("FAIL sm_flags got c=%b z=%b want %b %b", bus.c_flag_o, bus.z_flag_o, m_c, m_z);
        end
        for (int i = 1; i < NR; i++) begin
            bus.ra1_i = 3'(i); #1;
            checks++; if (bus.rd1_o !== m_r[i]) begin errors++; $display("FAIL sm_r%0d got %h want %h", i, bus.rd1_o, m_r[i]); end
        end
    endtask

    task automatic test_lm_stall();
        logic [DW-1:0] held;
        bus.mt_start_i = 1'b1; bus.mt_load_i = 1'b1; bus.mt_mask_i = 8'h0C;
        cycle();
        bus.mt_start_i = 1'b0;
        m_busy = 1'b1;
        bus.mt_ready_i = 1'b1; bus.mt_wdata_i = 16'hAAAA; #1;
        checks++; if (bus.mt_valid_o !== 1'b1 || bus.mt_idx_o !== 3'd2) begin
            errors++; $display("FAIL lm_first got v=%b idx=%0d want 1 2", bus.mt_valid_o, bus.mt_idx_o);
        end
        cycle(); m_r[2] = 16'hAAAA;
        bus.mt_ready_i = 1'b0; bus.mt_wdata_i = 16'h1111; #1;
        held = bus.mt_rdata_o;
        checks++; if (bus.mt_idx_o !== 3'd3 || held !== m_r[3]) begin
            errors++; $display("FAIL lm_stall got idx=%0d d=%h want 3 %h", bus.mt_idx_o, held, m_r[3]);
        end
        cycle();
        bus.mt_ready_i = 1'b1; bus.mt_wdata_i = 16'h5555; bus.ra2_i = 3'd3; #1;
        checks++; if (bus.mt_idx_o !== 3'd3 || bus.mt_rdata_o !== held || bus.mt_valid_o !== 1'b1) begin
            errors++; $display("FAIL lm_hold got idx=%0d d=%h v=%b want 3 %h 1", bus.mt_idx_o, bus.mt_rdata_o, bus.mt_valid_o, held);
        end
        checks++; if (bus.rd2_o !== 16'h5555) begin errors++; $display("FAIL lm_bypass got %h want 5555", bus.rd2_o); end
        cycle(); m_r[3] = 16'h5555;
        bus.mt_ready_i = 1'b0;
        checks++; if (bus.mt_done_o !== 1'b1) begin errors++; $display("FAIL lm_done got %b want 1", bus.mt_done_o); end
        cycle();
        m_busy = 1'b0;
        checks++; if (bus.mt_busy_o !== 1'b0) begin errors++; $display("FAIL lm_idle got %b want 0", bus.mt_busy_o); end
        for (int i = 1; i < NR; i++) begin
            bus.ra1_i = 3'(i); #1;
            checks++; if (bus.rd1_o !== m_r[i]) begin errors++; $display("FAIL lm_r%0d got %h want %h", i, bus.rd1_o, m_r[i]); end
        end
    endtask

    task automatic test_reset_abort();
        bus.mt_start_i = 1'b1; bus.mt_load_i = 1'b1; bus.mt_mask_i = 8'h1E;
        cycle();
        bus.mt_start_i = 1'b0;
        m_busy = 1'b1;
        bus.mt_ready_i = 1'b1; bus.mt_wdata_i = 16'h7777; #1;
        checks++; if (bus.mt_idx_o !== 3'd1) begin errors++; $display("FAIL abort_idx got %0d want 1", bus.mt_idx_o); end
        cycle(); m_r[1] = 16'h7777;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        bus.mt_ready_i = 1'b0;
        checks++; if (bus.mt_busy_o !== 1'b0 || bus.mt_valid_o !== 1'b0 || bus.mt_done_o !== 1'b0) begin
            errors++; $display("FAIL abort_state got b=%b v=%b d=%b want 0 0 0", bus.mt_busy_o, bus.mt_valid_o, bus.mt_done_o);
        end
        cycle();
        checks++; if (bus.mt_done_o !== 1'b0) begin errors++; $display("FAIL abort_nodone got %b want 0", bus.mt_done_o); end
        for (int i = 1; i < NR; i++) begin
            bus.ra1_i = 3'(i); #1;
            checks++; if (bus.rd1_o !== 16'h0000) begin errors++; $display("FAIL abort_r%0d got %h want 0000", i, bus.rd1_o); end
        end
    endtask

    task automatic test_empty_mask();
        bus.mt_start_i = 1'b1; bus.mt_load_i = 1'b0; bus.mt_mask_i = 8'h01;
        cycle();
        bus.mt_start_i = 1'b0;
        checks++; if (bus.mt_busy_o !== 1'b1 || bus.mt_valid_o !== 1'b0 || bus.mt_done_o !== 1'b1) begin
            errors++; $display("FAIL empty_done got b=%b v=%b d=%b want 1 0 1", bus.mt_busy_o, bus.mt_valid_o, bus.mt_done_o);
        end
        cycle();
        checks++; if (bus.mt_busy_o !== 1'b0 || bus.mt_done_o !== 1'b0) begin
            errors++; $display("FAIL empty_idle got b=%b d=%b want 0 0", bus.mt_busy_o, bus.mt_done_o);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1;
        bus.pc_i = '0; bus.ir_cz_i = '0; bus.f_sel_i = '0; bus.c_in_i = 1'b0; bus.z_in_i = 1'b0;
        bus.we_i = 1'b0; bus.ra1_i = '0; bus.ra2_i = '0; bus.wa_i = '0; bus.wd_i = '0;
        bus.mt_start_i = 1'b0; bus.mt_load_i = 1'b0; bus.mt_mask_i = '0;
        bus.mt_ready_i = 1'b0; bus.mt_wdata_i = '0;
        model_clear();
        test_reset();
        test_predicate();
        test_bypass();
        test_random();
        test_sm();
        test_lm_stall();
        test_reset_abort();
        test_empty_mask();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/regfile_mt.md
# regfile_mt

Parametrised general-purpose register file for the multicycle core: NREG registers of DATA_W bits with R0 mirroring the PC, carry/zero flag registers and flag-predicated writeback for ADC/ADZ-class instructions. It adds write-to-read bypass and a built-in multi-register transfer sequencer for LM/SM. The sequencer walks a register mask and streams one register per handshake to or from the memory datapath, so the controller does not need a per-register state loop.

## Interface
- DATA_W, 16, register and data width
- NREG, 8, register count; power of two, >= 4; AW = clog2(NREG)
- BYPASS, 1, 1 = forward same-cycle write data to read ports
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- pc  in  DATA_W  current PC, copied into R0 every cycle
- ir_cz  in  2  instruction CZ field (10 = write only if C, 01 = write only if Z)
- f_sel  in  3  ALU function select; 000 = add, < 011 = flag-affecting op
- c_in, z_in  in  1 each  ALU carry/zero results
- we  in  1  register write request
- ra1, ra2, wa  in  AW each  read addresses, write address
- wd  in  DATA_W  write data
- rd1, rd2  out  DATA_W  read data
- c_flag, z_flag  out  1 each  current flags
- mt_start  in  1  start multi-transfer (sampled in IDLE only)
- mt_load  in  1  1 = LM (memory to registers), 0 = SM (registers to memory)
- mt_mask  in  NREG  register mask, bit i selects Ri
- mt_valid  out  1  element presented
- mt_ready  in  1  datapath accepts/provides element this cycle
- mt_idx  out  AW  register index of current element
- mt_rdata  out  DATA_W  SM data (contents of R[mt_idx])
- mt_wdata  in  DATA_W  LM data
- mt_busy  out  1  sequencer not IDLE
- mt_done  out  1  one-cycle completion pulse

## Operation
- Predicate: wen = we & ~mt_busy & ~(ir_cz==10 & ~C) & ~(ir_cz==01 & ~Z), using pre-edge flags.
- wen & wa != 0 -> R[wa] <= wd. Writes to R0 are dropped; R0 <= pc every cycle, outranking all writes.
- Flags: we & ~mt_busy & f_sel==000 -> C <= c_in. we & ~mt_busy & f_sel < 011 -> Z <= z_in. Flag updates ignore the predicate; new values are visible the next cycle.
- Reads (combinational): ra == 0 -> 0.
- BYPASS=1: if a register write to address ra (ra != 0) occurs this cycle (normal or LM), rd = write data. Otherwise rd = R[ra].
- FSM states IDLE, XFER, DONE:
  - IDLE: on mt_start, latch rem = mt_mask with bit 0 forced 0, and latch mt_load. Go to XFER if rem != 0, else DONE.
  - XFER: mt_valid = 1; mt_idx = lowest set bit of rem; mt_rdata = R[mt_idx]. On mt_ready: LM -> R[mt_idx] <= mt_wdata; clear bit mt_idx in rem. If the new rem == 0, go to DONE.
  - DONE: mt_done = 1 for one cycle, then IDLE.
- mt_busy = state != IDLE. While busy, we and mt_start are ignored: no register or flag change from the normal port.
- mt_idx and mt_rdata are don't-care when mt_valid = 0. mt_rdata is not bypassed.

## Timing
- Reset (synchronous): all R cleared to 0 (including R0 on that edge), C = Z = 0, state IDLE, rem = 0. mt_valid, mt_busy, mt_done = 0. Reset mid-transfer aborts with no further writes and no mt_done.
- Normal write: data visible on rd from the edge after we (immediately when BYPASS=1).
- Multi-transfer: mt_start at edge k -> mt_busy/mt_valid high from k+1. With mt_ready held high, n selected registers take n cycles in XFER, mt_done is high in cycle k+n+1, and mt_busy falls at k+n+2.
- Empty mask (or only bit 0): DONE at k+1, no mt_valid.
- mt_ready low stalls; mt_idx and mt_rdata stay stable.
- Order is always ascending register index.

## Test plan
- Reset then pc=0x0040 -> R0 = 0x0040 one cycle later; rd1 with ra1=0 reads 0; c_flag = z_flag = 0.
- Set C=0, then ir_cz=10, we=1, wa=3, wd=0x1234, f_sel=000, c_in=1 -> R3 unchanged, C becomes 1. Repeat -> R3 = 0x1234.
- BYPASS=1: we=1, wa=5, wd=0xBEEF, ra2=5 in the same cycle -> rd2 = 0xBEEF combinationally. A write to wa=0 leaves R0 = pc.
- SM with mask 0b10100110 (R0 bit dropped), R1=1, R2=2, R5=5, R7=7, mt_ready high -> mt_idx sequence 1,2,5,7 with mt_rdata 1,2,5,7, then mt_done pulse. A concurrent we is ignored.
- LM with mask 0x0C, mt_ready toggled 1,0,1, mt_wdata 0xAAAA then 0x5555 -> R2 = 0xAAAA, R3 = 0x5555; mt_idx holds at 3 during the stall.
- Reset asserted in the second XFER cycle of a 4-register LM -> IDLE, all R = 0, no mt_done; mask 0 start -> mt_done after 1 cycle.
